// File: rtl/adc_acq_sequencer_if.sv
// Command, ADC and buffer-write signals shared between the AD7643 acquisition
// sequencer and its surroundings (USB command decoder, ADC pair, dmem/emem).
interface adc_acq_sequencer_if #(
   parameter int unsigned ADDR_W = 14
);
   logic              START;
   logic              STOP;
   logic              CLRPTR;
   logic [15:0]       PERIOD;
   logic [ADDR_W-1:0] NSAMP;
   logic              SDOUT0;
   logic              SDOUT1;
   logic              BUSY0;
   logic              BUSY1;
   logic              CNVST;
   logic              SCLK;
   logic              WE;
   logic [ADDR_W-1:0] WADDR;
   logic [15:0]       WDATA0;
   logic [15:0]       WDATA1;
   logic              RUNNING;
   logic              DONE;
   logic              BUSYERR;
   logic              OVR;

   // Command/ADC side: drives strobes and ADC pins, observes the sequencer.
   modport master (
      output START, STOP, CLRPTR, PERIOD, NSAMP, SDOUT0, SDOUT1, BUSY0, BUSY1,
      input  CNVST, SCLK, WE, WADDR, WDATA0, WDATA1, RUNNING, DONE, BUSYERR, OVR
   );

   // Sequencer side.
   modport slave (
      input  START, STOP, CLRPTR, PERIOD, NSAMP, SDOUT0, SDOUT1, BUSY0, BUSY1,
      output CNVST, SCLK, WE, WADDR, WDATA0, WDATA1, RUNNING, DONE, BUSYERR, OVR
   );
endinterface

// File: rtl/adc_acq_sequencer.sv
// Dual AD7643 acquisition sequencer: conversion start, busy wait, serial slave
// readout and one buffer write per sample pair, paced by a programmable period.
module adc_acq_sequencer #(
   parameter int unsigned NBITS     = 18,
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned SCLK_HALF = 1,
   parameter int unsigned CNV_LOW   = 2,
   parameter int unsigned BUSY_TMO  = 64
) (
   input logic                CLK,
   input logic                RST,
   adc_acq_sequencer_if.slave bus
);

   localparam int unsigned SW   = 16;
   localparam int unsigned PW   = 16;
   localparam int unsigned HC_W = $clog2(SCLK_HALF + 1);
   localparam int unsigned RC_W = $clog2(NBITS + 1);
   localparam int unsigned CC_W = $clog2(CNV_LOW + 1);
   localparam int unsigned WC_W = $clog2(BUSY_TMO + 1);
   localparam logic [PW-1:0] PMIN = PW'(8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_WAIT,
      S_SHIFT,
      S_STORE,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;

   logic [CC_W-1:0]   cc_q;
   logic [WC_W-1:0]   wc_q;
   logic [HC_W-1:0]   hc_q;
   logic [RC_W-1:0]   rc_q;
   logic [NBITS-1:0]  sh0_q, sh1_q;
   logic [PW-1:0]     pc_q, eff_q;
   logic [ADDR_W-1:0] addr_q, cnt_q;

   logic              cnvst_q, sclk_q, we_q, running_q, done_q, busyerr_q, ovr_q;
   logic [SW-1:0]     wdata0_q, wdata1_q;
   logic              cnvst_d, sclk_d, we_d, running_d, done_d, busyerr_d, ovr_d;
   logic [SW-1:0]     wdata0_d, wdata1_d;

   logic              abort, sclk_tick, busy_clear, busy_tmo, conv_entry, last_sample;
   logic [ADDR_W-1:0] cnt_inc;
   logic [PW-1:0]     hold_lim;

   assign abort       = bus.CLRPTR | bus.STOP;
   assign sclk_tick   = (hc_q == HC_W'(SCLK_HALF - 1));
   // BUSY is only trusted from the second WAIT cycle on, giving the ADC time to raise it.
   assign busy_clear  = (wc_q != '0) && !bus.BUSY0 && !bus.BUSY1;
   assign busy_tmo    = (wc_q == WC_W'(BUSY_TMO - 1));
   assign cnt_inc     = cnt_q + ADDR_W'(1);
   assign last_sample = (bus.NSAMP != '0) && (cnt_inc == bus.NSAMP);
   assign hold_lim    = eff_q - PW'(1);
   assign conv_entry  = (state_d == S_CONV) && (state_q != S_CONV);

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; CLRPTR and STOP override every transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.START) state_d = S_CONV;
         S_CONV:  if (cc_q == CC_W'(CNV_LOW - 1)) state_d = S_WAIT;
         S_WAIT:  if (busy_clear || busy_tmo) state_d = S_SHIFT;
         S_SHIFT: if (sclk_tick && sclk_q && (rc_q == RC_W'(NBITS))) state_d = S_STORE;
         S_STORE: state_d = last_sample ? S_IDLE : S_HOLD;
         S_HOLD:  if (pc_q >= hold_lim) state_d = S_CONV;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // Output logic: next values of the registered outputs, derived from the transition.
   always_comb begin
      cnvst_d   = 1'b1;
      sclk_d    = 1'b0;
      we_d      = 1'b0;
      done_d    = 1'b0;
      running_d = (state_d != S_IDLE);
      wdata0_d  = wdata0_q;
      wdata1_d  = wdata1_q;
      busyerr_d = busyerr_q;
      ovr_d     = ovr_q;

      if (state_d == S_CONV) cnvst_d = 1'b0;
      if ((state_d == S_SHIFT) && (state_q == S_SHIFT)) sclk_d = sclk_tick ? ~sclk_q : sclk_q;
      if (state_d == S_STORE) begin
         we_d     = 1'b1;
         wdata0_d = SW'(sh0_q >> 2);
         wdata1_d = SW'(sh1_q >> 2);
      end
      if ((state_q == S_STORE) && (state_d == S_IDLE) && !abort) done_d = 1'b1;
      if ((state_q == S_WAIT) && (state_d == S_SHIFT) && !busy_clear) busyerr_d = 1'b1;
      // Overrun: the period had already expired when the hold was reached.
      if ((state_q == S_HOLD) && (state_d == S_CONV) && (pc_q > hold_lim)) ovr_d = 1'b1;
      if (bus.CLRPTR) begin
         busyerr_d = 1'b0;
         ovr_d     = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnvst_q   <= 1'b1;
         sclk_q    <= 1'b0;
         we_q      <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         busyerr_q <= 1'b0;
         ovr_q     <= 1'b0;
         wdata0_q  <= '0;
         wdata1_q  <= '0;
      end else begin
         cnvst_q   <= cnvst_d;
         sclk_q    <= sclk_d;
         we_q      <= we_d;
         running_q <= running_d;
         done_q    <= done_d;
         busyerr_q <= busyerr_d;
         ovr_q     <= ovr_d;
         wdata0_q  <= wdata0_d;
         wdata1_q  <= wdata1_d;
      end
   end

   // Datapath: phase counters, shift registers, period pacing, address and count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cc_q   <= '0;
         wc_q   <= '0;
         hc_q   <= '0;
         rc_q   <= '0;
         sh0_q  <= '0;
         sh1_q  <= '0;
         pc_q   <= '0;
         eff_q  <= PMIN;
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         cc_q <= (state_q == S_CONV) ? cc_q + CC_W'(1) : '0;
         wc_q <= (state_q == S_WAIT) ? wc_q + WC_W'(1) : '0;

         // Shift registers start empty for every word; a stopped word is simply dropped.
         if (state_q != S_SHIFT) begin
            hc_q  <= '0;
            rc_q  <= '0;
            sh0_q <= '0;
            sh1_q <= '0;
         end else begin
            hc_q <= sclk_tick ? '0 : hc_q + HC_W'(1);
            if (sclk_tick && !sclk_q) begin
               rc_q  <= rc_q + RC_W'(1);
               sh0_q <= {sh0_q[NBITS-2:0], bus.SDOUT0};
               sh1_q <= {sh1_q[NBITS-2:0], bus.SDOUT1};
            end
         end

         if (conv_entry) begin
            pc_q  <= '0;
            eff_q <= (bus.PERIOD < PMIN) ? PMIN : bus.PERIOD;
         end else if ((state_q != S_IDLE) && (pc_q != '1)) begin
            pc_q <= pc_q + PW'(1);
         end

         if (bus.CLRPTR) begin
            addr_q <= '0;
            cnt_q  <= '0;
         end else if (state_q == S_STORE) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= last_sample ? '0 : cnt_inc;
         end
      end
   end

   assign bus.CNVST   = cnvst_q;
   assign bus.SCLK    = sclk_q;
   assign bus.WE      = we_q;
   assign bus.WADDR   = addr_q;
   assign bus.WDATA0  = wdata0_q;
   assign bus.WDATA1  = wdata1_q;
   assign bus.RUNNING = running_q;
   assign bus.DONE    = done_q;
   assign bus.BUSYERR = busyerr_q;
   assign bus.OVR     = ovr_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer: a 14-bit-address instance with SCLK_HALF=1
// and a 4-bit-address instance with SCLK_HALF=2, each fed by a small AD7643 model.
module tb_adc_acq_sequencer;

   localparam int unsigned NB   = 18;
   localparam int unsigned AW_A = 14;
   localparam int unsigned AW_B = 4;

   logic CLK = 1'b0;
   logic rst_a, rst_b;
   always #5 CLK = ~CLK;

   adc_acq_sequencer_if #(.ADDR_W(AW_A)) bus_a ();
   adc_acq_sequencer_if #(.ADDR_W(AW_B)) bus_b ();

   adc_acq_sequencer #(.NBITS(NB), .ADDR_W(AW_A), .SCLK_HALF(1), .CNV_LOW(2), .BUSY_TMO(64))
      u_dut_a (.CLK(CLK), .RST(rst_a), .bus(bus_a));

   adc_acq_sequencer #(.NBITS(NB), .ADDR_W(AW_B), .SCLK_HALF(2), .CNV_LOW(2), .BUSY_TMO(64))
      u_dut_b (.CLK(CLK), .RST(rst_b), .bus(bus_b));

   // ADC models: BUSY high for 10 cycles after CNVST low, MSB-first word advanced on SCLK fall.
   logic [NB-1:0] word0 = 18'h2AAAA;
   logic [NB-1:0] word1 = 18'h15555;
   logic [NB-1:0] d0_a = '0, d1_a = '0, d0_b = '0, d1_b = '0;
   int            bcnt_a = 0, bcnt_b = 0;
   logic          sprev_a = 1'b0, sprev_b = 1'b0;
   logic          stuck_a = 1'b0;

   assign bus_a.BUSY0  = (bcnt_a != 0) || stuck_a;
   assign bus_a.BUSY1  = (bcnt_a != 0);
   assign bus_a.SDOUT0 = d0_a[NB-1];
   assign bus_a.SDOUT1 = d1_a[NB-1];
   assign bus_b.BUSY0  = (bcnt_b != 0);
   assign bus_b.BUSY1  = (bcnt_b != 0);
   assign bus_b.SDOUT0 = d0_b[NB-1];
   assign bus_b.SDOUT1 = d1_b[NB-1];

   always @(negedge CLK) begin
      if (!bus_a.CNVST) begin
         bcnt_a = 10; d0_a = word0; d1_a = word1;
      end else begin
         if (bcnt_a != 0) bcnt_a = bcnt_a - 1;
         if (sprev_a && !bus_a.SCLK) begin d0_a = d0_a << 1; d1_a = d1_a << 1; end
      end
      sprev_a = bus_a.SCLK;
   end

   always @(negedge CLK) begin
      if (!bus_b.CNVST) begin
         bcnt_b = 10; d0_b = word0; d1_b = word1;
      end else begin
         if (bcnt_b != 0) bcnt_b = bcnt_b - 1;
         if (sprev_b && !bus_b.SCLK) begin d0_b = d0_b << 1; d1_b = d1_b << 1; end
      end
      sprev_b = bus_b.SCLK;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n_we, last_t, rises, n;
      logic done_seen, sp;

      bus_a.START = 1'b0; bus_a.STOP = 1'b0; bus_a.CLRPTR = 1'b0;
      bus_a.PERIOD = 16'd100; bus_a.NSAMP = '0;
      bus_b.START = 1'b0; bus_b.STOP = 1'b0; bus_b.CLRPTR = 1'b0;
      bus_b.PERIOD = 16'd20; bus_b.NSAMP = '0;
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (3) @(negedge CLK);

      // Reset values
      chk("rst_cnvst",   32'(bus_a.CNVST), 1);
      chk("rst_sclk",    32'(bus_a.SCLK), 0);
      chk("rst_we",      32'(bus_a.WE), 0);
      chk("rst_waddr",   32'(bus_a.WADDR), 0);
      chk("rst_wdata0",  32'(bus_a.WDATA0), 0);
      chk("rst_running", 32'(bus_a.RUNNING), 0);
      chk("rst_done",    32'(bus_a.DONE), 0);
      chk("rst_busyerr", 32'(bus_a.BUSYERR), 0);
      chk("rst_ovr_b",   32'(bus_b.OVR), 0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge CLK);

      // Basic readout: NSAMP=3, PERIOD=100
      bus_a.NSAMP = 14'd3;
      bus_a.START = 1'b1; @(negedge CLK); bus_a.START = 1'b0;
      chk("start_running", 32'(bus_a.RUNNING), 1);
      chk("start_cnvst",   32'(bus_a.CNVST), 0);
      n_we = 0; last_t = 0; done_seen = 1'b0;
      for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
         if (bus_a.WE) begin
            chk("basic_waddr",  32'(bus_a.WADDR), 32'(n_we));
            chk("basic_wdata0", 32'(bus_a.WDATA0), 32'h0000AAAA);
            chk("basic_wdata1", 32'(bus_a.WDATA1), 32'h00005555);
            if (n_we > 0) chk("basic_spacing", 32'(cyc - last_t), 100);
            last_t = cyc;
            n_we++;
         end
         if (bus_a.DONE) begin
            done_seen = 1'b1;
            chk("done_running", 32'(bus_a.RUNNING), 0);
         end
         @(negedge CLK);
      end
      chk("basic_we_count", 32'(n_we), 3);
      chk("basic_done", 32'(done_seen), 1);
      chk("basic_done_width", 32'(bus_a.DONE), 0);
      chk("basic_waddr_end", 32'(bus_a.WADDR), 3);

      // Abort at the 9th SCLK rise of a continuous run
      bus_a.NSAMP = '0;
      bus_a.START = 1'b1; @(negedge CLK); bus_a.START = 1'b0;
      rises = 0; sp = 1'b0;
      for (int cyc = 0; cyc < 200 && rises < 9; cyc++) begin
         @(negedge CLK);
         if (bus_a.SCLK && !sp) rises++;
         sp = bus_a.SCLK;
      end
      chk("abort_bit9_reached", 32'(rises), 9);
      bus_a.STOP = 1'b1; @(negedge CLK); bus_a.STOP = 1'b0;
      chk("abort_sclk",    32'(bus_a.SCLK), 0);
      chk("abort_running", 32'(bus_a.RUNNING), 0);
      chk("abort_cnvst",   32'(bus_a.CNVST), 1);
      n_we = 0;
      repeat (150) begin
         if (bus_a.WE) n_we++;
         @(negedge CLK);
      end
      chk("abort_no_we", 32'(n_we), 0);
      chk("abort_waddr", 32'(bus_a.WADDR), 3);

      // CLRPTR together with START
      bus_a.CLRPTR = 1'b1; bus_a.START = 1'b1; @(negedge CLK);
      bus_a.CLRPTR = 1'b0; bus_a.START = 1'b0;
      chk("clr_waddr",   32'(bus_a.WADDR), 0);
      chk("clr_running", 32'(bus_a.RUNNING), 0);
      repeat (5) @(negedge CLK);
      chk("clr_start_ignored", 32'(bus_a.RUNNING), 0);

      // Busy timeout with BUSY0 stuck high
      stuck_a = 1'b1; bus_a.NSAMP = 14'd1;
      bus_a.START = 1'b1; @(negedge CLK); bus_a.START = 1'b0;
      for (int i = 0; i < 10 && !bus_a.CNVST; i++) @(negedge CLK);
      n = 0;
      while (!bus_a.SCLK && n < 200) begin n++; @(negedge CLK); end
      chk("tmo_wait_len", 32'(n), 65);
      chk("tmo_busyerr", 32'(bus_a.BUSYERR), 1);
      for (int i = 0; i < 100 && !bus_a.WE; i++) @(negedge CLK);
      chk("tmo_we", 32'(bus_a.WE), 1);
      chk("tmo_waddr", 32'(bus_a.WADDR), 0);
      chk("tmo_wdata0", 32'(bus_a.WDATA0), 32'h0000AAAA);
      @(negedge CLK);
      chk("tmo_done", 32'(bus_a.DONE), 1);
      stuck_a = 1'b0;

      // Reset while CNVST is low
      bus_a.NSAMP = '0;
      bus_a.START = 1'b1; @(negedge CLK); bus_a.START = 1'b0;
      chk("rconv_cnvst_low", 32'(bus_a.CNVST), 0);
      chk("rconv_pre_busyerr", 32'(bus_a.BUSYERR), 1);
      chk("rconv_pre_waddr", 32'(bus_a.WADDR), 1);
      rst_a = 1'b1; @(negedge CLK);
      chk("rconv_cnvst",   32'(bus_a.CNVST), 1);
      chk("rconv_running", 32'(bus_a.RUNNING), 0);
      chk("rconv_waddr",   32'(bus_a.WADDR), 0);
      chk("rconv_wdata1",  32'(bus_a.WDATA1), 0);
      chk("rconv_busyerr", 32'(bus_a.BUSYERR), 0);
      rst_a = 1'b0;

      // Overrun on instance B: PERIOD=20, NSAMP=3
      bus_b.NSAMP = 4'd3;
      bus_b.START = 1'b1; @(negedge CLK); bus_b.START = 1'b0;
      n_we = 0; done_seen = 1'b0;
      for (int cyc = 0; cyc < 1000 && !done_seen; cyc++) begin
         @(negedge CLK);
         if (bus_b.DONE) done_seen = 1'b1;
         if (bus_b.WE) begin
            chk("ovr_waddr",  32'(bus_b.WADDR), 32'(n_we));
            chk("ovr_wdata1", 32'(bus_b.WDATA1), 32'h00005555);
            n_we++;
            if (n_we < 3) begin
               @(negedge CLK);
               chk("ovr_hold_cnvst", 32'(bus_b.CNVST), 1);
               @(negedge CLK);
               chk("ovr_back_to_back", 32'(bus_b.CNVST), 0);
               chk("ovr_flag", 32'(bus_b.OVR), 1);
            end
         end
      end
      chk("ovr_we_count", 32'(n_we), 3);
      chk("ovr_done", 32'(done_seen), 1);

      // Address wrap on instance B: continuous, 18 samples
      bus_b.CLRPTR = 1'b1; @(negedge CLK); bus_b.CLRPTR = 1'b0;
      chk("wrap_clr_ovr", 32'(bus_b.OVR), 0);
      chk("wrap_clr_waddr", 32'(bus_b.WADDR), 0);
      bus_b.PERIOD = 16'd8; bus_b.NSAMP = '0;
      bus_b.START = 1'b1; @(negedge CLK); bus_b.START = 1'b0;
      n_we = 0;
      for (int cyc = 0; cyc < 2500 && n_we < 18; cyc++) begin
         @(negedge CLK);
         if (bus_b.WE) begin
            chk("wrap_waddr", 32'(bus_b.WADDR), 32'(n_we % 16));
            n_we++;
         end
      end
      chk("wrap_we_count", 32'(n_we), 18);
      repeat (3) @(negedge CLK);
      bus_b.STOP = 1'b1; @(negedge CLK); bus_b.STOP = 1'b0;
      chk("wrap_stop_running", 32'(bus_b.RUNNING), 0);
      chk("wrap_stop_waddr", 32'(bus_b.WADDR), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
